// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings and word geometry.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted bytes little-endian into 32-bit words; o_word_ready pulses
// combinationally on the cycle the final byte of a word is being accepted.
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        i_srst,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // Bytes enter at the top and shift down, so the first byte ends up in bits 7:0.
    always_ff @(posedge clk) begin
        if (i_srst || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_accept) begin
            r_shift <= {i_byte, r_shift[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign o_word_ready = i_accept && (r_cnt == 2'(WORD_BYTES - 1));
    assign o_word       = {i_byte, r_shift};

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader that writes the instruction memory and holds the CPU
// in reset until the image is in place. Define IMEM_LOADER_CHECKSUM_EN for a trailing sum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [31:0]           imem_wr_data,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_len;
    logic [CNT_W-1:0]      r_word_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;

    logic        w_accept;
    logic        w_start_ok;
    logic        w_word_ready;
    logic [31:0] w_word;
    logic        w_hdr_bad;
    logic        w_last_word;
    logic        w_chk_ok;

    assign in_ready   = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_accept   = in_valid && in_ready;
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));

    // The checksum byte never enters the assembler, so its counter stays word-aligned.
    imem_loader_byte_assembler u_asm (
        .clk          (clk),
        .i_srst       (reset),
        .i_clear      (w_start_ok),
        .i_accept     (w_accept && (r_state != ST_CHECK)),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    assign w_hdr_bad   = (w_word == 32'd0) || (w_word > 32'(MAX_WORDS));
    assign w_last_word = (r_word_cnt + CNT_W'(1)) == r_len;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_sum <= '0;
        end else if (w_accept && (r_state == ST_DATA)) begin
            r_sum <= r_sum + in_data;
        end
    end

    assign w_chk_ok = (in_data == r_sum);
`else
    assign w_chk_ok = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: if (w_start_ok) w_state_next = ST_HDR;
            ST_HDR:   if (w_word_ready) w_state_next = w_hdr_bad ? ST_ERR : ST_DATA;
            ST_DATA:  if (w_word_ready) w_state_next = ST_WRITE;
            ST_WRITE: begin
                if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_next = ST_CHECK;
`else
                    w_state_next = ST_DONE;
`endif
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            ST_CHECK: if (w_accept) w_state_next = w_chk_ok ? ST_DONE : ST_ERR;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= BASE_ADDR;
            r_wdata    <= '0;
            r_len      <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_word_cnt <= '0;
            end
            // Header range is checked before truncation, so a stored length always fits CNT_W.
            if ((r_state == ST_HDR) && w_word_ready) begin
                r_len  <= w_word[CNT_W-1:0];
                r_addr <= BASE_ADDR;
            end
            if ((r_state == ST_DATA) && w_word_ready) begin
                r_wdata <= w_word;
            end
            if (r_state == ST_WRITE) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
                r_addr     <= r_addr + ADDR_WIDTH'(WORD_BYTES);
            end
        end
    end

    assign imem_wr_en   = (r_state == ST_WRITE);
    assign imem_wr_addr = r_addr;
    assign imem_wr_data = r_wdata;
    assign busy         = (r_state == ST_HDR) || (r_state == ST_DATA) ||
                          (r_state == ST_WRITE) || (r_state == ST_CHECK);
    assign done         = (r_state == ST_DONE);
    assign error        = (r_state == ST_ERR);
    assign cpu_reset    = (r_state != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams with random gaps, checked against a
// queue-based model of the expected memory image and final status.
module tb_imem_loader;

    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MAXW = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [31:0]   imem_wr_data;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    imem_loader #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .MAX_WORDS  (MAXW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // Observed write strobes and done-entry behaviour
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          wr_ready_viol = 0;
    logic        done_d = 1'b0;
    logic        cr_d = 1'b1;
    logic        cr_at_entry = 1'bx;
    logic        cr_before = 1'bx;

    always @(negedge clk) begin
        if (imem_wr_en) begin
            wr_addr_q.push_back(imem_wr_addr);
            wr_data_q.push_back(imem_wr_data);
            wr_cyc_q.push_back(cyc);
            if (in_ready) wr_ready_viol++;
        end
        if (done && !done_d) begin
            cr_at_entry = cpu_reset;
            cr_before   = cr_d;
        end
        done_d = done;
        cr_d   = cpu_reset;
    end

    // Reference model state
    logic [31:0] exp_words[$];
    logic [31:0] fixed_words[$];
    logic        exp_ok;

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int n;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL handshake: in_ready=%b for byte %02h after %0d cycles, required 1", in_ready, b, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Drives one complete load and records the expected image and outcome.
    task automatic do_load(input logic [31:0] len, input int gap_max, input bit bad_sum,
                           input int poke_at, input bit use_fixed);
        logic [31:0] w;
        logic [7:0]  sum;
        bit          len_ok;
        int          n;
        exp_words.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        sum    = 8'd0;
        len_ok = (len != 0) && (len <= 32'(MAXW));
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(8'(len >> (8 * k)), gap_max);
        if (len_ok) begin
            for (int i = 0; i < int'(len); i++) begin
                if (i == poke_at) pulse_start();
                w = use_fixed ? fixed_words[i] : $urandom;
                exp_words.push_back(w);
                for (int k = 0; k < 4; k++) begin
                    sum = sum + w[8*k +: 8];
                    send_byte(w[8*k +: 8], gap_max);
                end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (len_ok) send_byte(bad_sum ? sum + 8'd1 : sum, gap_max);
        exp_ok = len_ok && !bad_sum;
`else
        exp_ok = len_ok;
`endif
        n = 0;
        while (!(done || error) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) begin
            tests++; fails++;
            $display("FAIL load_timeout: done=%b error=%b after %0d cycles, required one of them 1", done, error, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        tests++; if ({in_ready, imem_wr_en, busy, done, error} !== 5'b0) begin fails++;
            $display("FAIL reset_flags: rdy/wr/busy/done/err=%b required 00000", {in_ready, imem_wr_en, busy, done, error}); end
        tests++; if (cpu_reset !== 1'b1) begin fails++;
            $display("FAIL reset_cpu_reset: got %b required 1", cpu_reset); end
        tests++; if (imem_wr_addr !== BASE || imem_wr_data !== 32'h0) begin fails++;
            $display("FAIL reset_addr_data: addr=%h data=%h required %h/00000000", imem_wr_addr, imem_wr_data, BASE); end
        reset = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b0 || busy !== 1'b0 || wr_addr_q.size() != 0) begin fails++;
            $display("FAIL idle_ignores_bytes: in_ready=%b busy=%b writes=%0d required 0/0/0", in_ready, busy, wr_addr_q.size()); end
        $display("[TB] reset: checked reset and idle values");
    endtask

    task automatic test_happy_path();
        fixed_words.delete();
        fixed_words.push_back(32'h0050_0093);
        fixed_words.push_back(32'h00A0_0113);
        do_load(32'd2, 0, 1'b0, -1, 1'b1);
        tests++; if (wr_addr_q.size() != 2) begin fails++;
            $display("FAIL happy_count: writes=%0d required 2", wr_addr_q.size()); end
        for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
            tests++; if (wr_data_q[i] !== fixed_words[i] || wr_addr_q[i] !== BASE + 32'(4 * i)) begin fails++;
                $display("FAIL happy_word%0d: %h@%h required %h@%h", i, wr_data_q[i], wr_addr_q[i], fixed_words[i], BASE + 32'(4 * i)); end
        end
        tests++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin fails++;
            $display("FAIL happy_status: done=%b error=%b busy=%b required 1/0/0", done, error, busy); end
        tests++; if (cr_at_entry !== 1'b0 || cr_before !== 1'b1) begin fails++;
            $display("FAIL happy_cpu_reset_edge: at_done=%b before=%b required 0/1", cr_at_entry, cr_before); end
        $display("[TB] happy path: 2 words loaded, done=%b", done);
    endtask

    task automatic test_bad_header();
        logic [31:0] lens[3];
        lens[0] = 32'd0; lens[1] = 32'(MAXW + 1); lens[2] = 32'h8000_0001;
        for (int t = 0; t < 3; t++) begin
            do_load(lens[t], 1, 1'b0, -1, 1'b0);
            tests++; if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b0) begin fails++;
                $display("FAIL bad_hdr_status L=%h: err=%b done=%b cpu_reset=%b busy=%b required 1/0/1/0", lens[t], error, done, cpu_reset, busy); end
            tests++; if (wr_addr_q.size() != 0) begin fails++;
                $display("FAIL bad_hdr_writes L=%h: writes=%0d required 0", lens[t], wr_addr_q.size()); end
            $display("[TB] bad header L=%h: error=%b", lens[t], error);
        end
    endtask

    task automatic test_random_loads();
        for (int t = 0; t < 6; t++) begin
            logic [31:0] len;
            len = 32'($urandom_range(8, 1));
            do_load(len, 3, 1'b0, -1, 1'b0);
            tests++; if (wr_addr_q.size() != exp_words.size()) begin fails++;
                $display("FAIL rand_count%0d: writes=%0d required %0d", t, wr_addr_q.size(), exp_words.size()); end
            for (int i = 0; i < exp_words.size() && i < wr_addr_q.size(); i++) begin
                tests++; if (wr_data_q[i] !== exp_words[i] || wr_addr_q[i] !== BASE + 32'(4 * i)) begin fails++;
                    $display("FAIL rand_word%0d_%0d: %h@%h required %h@%h", t, i, wr_data_q[i], wr_addr_q[i], exp_words[i], BASE + 32'(4 * i)); end
            end
            tests++; if (done !== exp_ok || error !== !exp_ok || cpu_reset !== !exp_ok) begin fails++;
                $display("FAIL rand_status%0d: done=%b error=%b cpu_reset=%b required %b/%b/%b", t, done, error, cpu_reset, exp_ok, !exp_ok, !exp_ok); end
            $display("[TB] random load %0d: %0d words with gaps, writes=%0d", t, len, wr_addr_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int viol0;
        viol0 = wr_ready_viol;
        do_load(32'd6, 0, 1'b0, -1, 1'b0);
        tests++; if (wr_cyc_q.size() != 6) begin fails++;
            $display("FAIL b2b_count: writes=%0d required 6", wr_cyc_q.size()); end
        for (int i = 1; i < wr_cyc_q.size(); i++) begin
            tests++; if (wr_cyc_q[i] - wr_cyc_q[i-1] != 5) begin fails++;
                $display("FAIL b2b_spacing%0d: %0d cycles required 5", i, wr_cyc_q[i] - wr_cyc_q[i-1]); end
        end
        tests++; if (wr_ready_viol != viol0) begin fails++;
            $display("FAIL b2b_ready_in_write: %0d strobes with in_ready=1 required 0", wr_ready_viol - viol0); end
        $display("[TB] back-to-back: 6 words, strobe spacing checked");
    endtask

    task automatic test_max_len();
        do_load(32'(MAXW), 0, 1'b0, -1, 1'b0);
        tests++; if (wr_addr_q.size() != MAXW || done !== 1'b1) begin fails++;
            $display("FAIL max_len: writes=%0d done=%b required %0d/1", wr_addr_q.size(), done, MAXW); end
        if (wr_addr_q.size() == MAXW) begin
            tests++; if (wr_addr_q[MAXW-1] !== BASE + 32'(4 * (MAXW - 1)) || wr_data_q[MAXW-1] !== exp_words[MAXW-1]) begin fails++;
                $display("FAIL max_len_last: %h@%h required %h@%h", wr_data_q[MAXW-1], wr_addr_q[MAXW-1], exp_words[MAXW-1], BASE + 32'(4 * (MAXW - 1))); end
        end
        $display("[TB] max length: %0d words, done=%b", wr_addr_q.size(), done);
    endtask

    task automatic test_start_ignored();
        do_load(32'd3, 1, 1'b0, 1, 1'b0);
        tests++; if (wr_addr_q.size() != 3 || done !== 1'b1) begin fails++;
            $display("FAIL start_ignored: writes=%0d done=%b required 3/1", wr_addr_q.size(), done); end
        for (int i = 0; i < 3 && i < wr_data_q.size(); i++) begin
            tests++; if (wr_data_q[i] !== exp_words[i]) begin fails++;
                $display("FAIL start_ignored_word%0d: %h required %h", i, wr_data_q[i], exp_words[i]); end
        end
        $display("[TB] start during DATA ignored: writes=%0d", wr_addr_q.size());
    endtask

    task automatic test_mid_reset();
        logic [31:0] w;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(8'(32'd3 >> (8 * k)), 0);
        for (int i = 0; i < 2; i++) begin
            w = $urandom | 32'h1;
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++; if ({in_ready, imem_wr_en, busy, done, error} !== 5'b0 || cpu_reset !== 1'b1) begin fails++;
            $display("FAIL midreset_flags: rdy/wr/busy/done/err=%b cpu_reset=%b required 00000/1", {in_ready, imem_wr_en, busy, done, error}, cpu_reset); end
        tests++; if (imem_wr_addr !== BASE || imem_wr_data !== 32'h0) begin fails++;
            $display("FAIL midreset_addr_data: %h@%h required 00000000@%h", imem_wr_data, imem_wr_addr, BASE); end
        tests++; if (wr_addr_q.size() != 2) begin fails++;
            $display("FAIL midreset_partial: writes=%0d required 2", wr_addr_q.size()); end
        reset = 1'b0;
        @(negedge clk);
        do_load(32'd2, 1, 1'b0, -1, 1'b0);
        tests++; if (wr_addr_q.size() != 2 || done !== 1'b1) begin fails++;
            $display("FAIL midreset_reload: writes=%0d done=%b required 2/1", wr_addr_q.size(), done); end
        if (wr_addr_q.size() > 0) begin
            tests++; if (wr_addr_q[0] !== BASE || wr_data_q[0] !== exp_words[0]) begin fails++;
                $display("FAIL midreset_first: %h@%h required %h@%h", wr_data_q[0], wr_addr_q[0], exp_words[0], BASE); end
        end
        $display("[TB] mid-load reset: aborted after 2 words, fresh load ok");
    endtask

    task automatic test_reload();
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b0 || done !== 1'b1) begin fails++;
            $display("FAIL done_ignores_bytes: in_ready=%b done=%b required 0/1", in_ready, done); end
        pulse_start();
        tests++; if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin fails++;
            $display("FAIL reload_start: cpu_reset=%b done=%b busy=%b in_ready=%b required 1/0/1/1", cpu_reset, done, busy, in_ready); end
        // do_load's own start pulse lands in HDR and must be ignored
        do_load(32'd1, 0, 1'b0, -1, 1'b0);
        tests++; if (wr_addr_q.size() != 1 || done !== 1'b1) begin fails++;
            $display("FAIL reload_result: writes=%0d done=%b required 1/1", wr_addr_q.size(), done); end
        if (wr_addr_q.size() > 0) begin
            tests++; if (wr_addr_q[0] !== BASE || wr_data_q[0] !== exp_words[0]) begin fails++;
                $display("FAIL reload_first: %h@%h required %h@%h", wr_data_q[0], wr_addr_q[0], exp_words[0], BASE); end
        end
        $display("[TB] reload from DONE: first write at %h", BASE);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_load(32'd3, 2, 1'b0, -1, 1'b0);
        tests++; if (done !== 1'b1 || error !== 1'b0 || cpu_reset !== 1'b0) begin fails++;
            $display("FAIL checksum_good: done=%b error=%b cpu_reset=%b required 1/0/0", done, error, cpu_reset); end
        do_load(32'd3, 2, 1'b1, -1, 1'b0);
        tests++; if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin fails++;
            $display("FAIL checksum_bad: error=%b done=%b cpu_reset=%b required 1/0/1", error, done, cpu_reset); end
        tests++; if (wr_addr_q.size() != 3) begin fails++;
            $display("FAIL checksum_bad_writes: writes=%0d required 3", wr_addr_q.size()); end
        $display("[TB] checksum: good and off-by-one sums checked");
    endtask
`endif

    initial begin
        test_reset();
        test_happy_path();
        test_bad_header();
        test_random_loads();
        test_back_to_back();
        test_start_ignored();
        test_mid_reset();
        test_reload();
        test_max_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the write side of the instruction memory that the CPU only reads.
- Accepts a length-prefixed, little-endian byte stream and assembles 32-bit instruction words.
- Writes each word to the instruction memory write port at consecutive word addresses.
- Holds the CPU in reset until the image is fully and correctly loaded; sits between a host link (UART/JTAG byte source) and the ROM/CPU pair.

Parameters:
- ADDR_WIDTH, 32, width of imem_wr_addr (byte address).
- BASE_ADDR, 0, byte address of the first written word; must be a multiple of 4.
- MAX_WORDS, 256, instruction memory depth in words; a header length above this is an error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load; honoured only in IDLE, DONE or ERR
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader can accept a byte this cycle
- imem_wr_en  out  1  one-cycle instruction memory write strobe
- imem_wr_addr  out  ADDR_WIDTH  byte address of the word being written
- imem_wr_data  out  32  assembled instruction word
- cpu_reset  out  1  active-high reset to the CPU
- busy  out  1  a load is in progress
- done  out  1  the last load completed successfully (level)
- error  out  1  the last load failed (level)

Behaviour:
- Reset (sync, active-high) values: state IDLE, in_ready 0, imem_wr_en 0, imem_wr_addr BASE_ADDR, imem_wr_data 0, cpu_reset 1, busy 0, done 0, error 0.
- Reset asserted mid-load aborts the load on that edge and returns all outputs to their reset values; words already written are not undone.
- Byte transfer: a byte is accepted on a rising edge where in_valid and in_ready are both 1. in_data is ignored otherwise.
- States:
  - IDLE: in_ready 0. On start → HDR; clear byte_cnt, word_cnt, done, error; set busy; cpu_reset stays 1.
  - HDR: in_ready 1. Accept 4 bytes, little-endian, as length L (words). After the 4th byte:
    - L == 0 or L > MAX_WORDS → ERR.
    - Otherwise → DATA, with imem_wr_addr = BASE_ADDR.
  - DATA: in_ready 1. Shift accepted bytes into the word, little-endian (1st byte → bits 7:0). On the edge accepting the 4th byte → WRITE, with imem_wr_data loaded.
  - WRITE: lasts exactly 1 cycle. imem_wr_en 1, in_ready 0.
    - Next edge: word_cnt+1 and imem_wr_addr += 4.
    - If word_cnt+1 == L → CHECK (feature on) or DONE (feature off).
    - Otherwise → DATA.
  - DONE: in_ready 0, busy 0, done 1, cpu_reset 0. start → HDR.
  - ERR: in_ready 0, busy 0, error 1, cpu_reset 1. start → HDR.
- Latency: the write strobe is asserted the cycle after the 4th byte of a word is accepted. Sustained throughput is 1 word per 5 cycles.
- cpu_reset deasserts the cycle DONE is entered. It reasserts on the edge a new start is accepted.
- start in HDR/DATA/WRITE/CHECK is ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH (unreachable when MAX_WORDS is in range).
- in_valid gaps of any length are tolerated; no timeout.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - Add state CHECK with in_ready 1; accept one byte.
  - A running 8-bit sum (mod 256) is kept over all data bytes (header excluded).
  - Match → DONE; mismatch → ERR.
- Undefined: no CHECK state; the last WRITE goes directly to DONE; no checksum logic is instantiated.

Decomposition:
- Shared parameters include file: state encodings (IDLE, HDR, DATA, WRITE, CHECK, DONE, ERR) and WORD_BYTES = 4.
- One sub-module, byte_assembler: shift register plus 2-bit byte counter with a word_ready pulse. It is used for both the header and data words.

Test Plan:
- Happy path: start; stream 02 00 00 00, 93 00 50 00, 13 01 A0 00 → writes 0x00500093 @0x0 and 0x00A00113 @0x4; done=1; cpu_reset=0 the cycle DONE is entered.
- Zero and oversize headers: L=0 → error=1, no imem_wr_en, cpu_reset=1. L=257 with MAX_WORDS=256 → same response.
- Backpressure and gaps: in_valid toggled 1-0-0-1 across bytes → identical writes; exactly one imem_wr_en per word; in_ready 0 during WRITE.
- Mid-load reset: assert reset after 2 of 3 words → all outputs at reset values. A fresh start then loads from BASE_ADDR again.
- Checksum (macro on): correct sum byte → done. Sum byte off by 1 → error=1 and cpu_reset remains 1.
- Reload from DONE: start while in DONE → cpu_reset reasserts the next cycle and done clears. With BASE_ADDR=0x100, the first write lands at 0x100.
